bt_status_tx: RTL
=================

# bt_status_tx

Bluetooth status transmitter: the return path of the Bluetooth UART link. The game's Bluetooth receiver turns incoming serial bytes into direction and menu commands. This block serializes the current game status (state, score, miss, life) into 4-byte UART frames and drives them to the Bluetooth module's RX pin, so the phone app can mirror the game. It sits in `top` beside the receiver and reads the same `state`, `score`, `miss` and `life` nets.

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000, system clock frequency in Hz.
- `BAUD`, 9600, UART bit rate. `DIV = CLK_FREQ/BAUD` uses integer (truncating) division and must be ≥ 2.

Ports:
- `clk` input 1: system clock; the block has one clock.
- `rst` input 1: reset, asynchronous and active-low.
- `state` input 3: game state code from the controller.
- `score` input 4: hit count.
- `miss` input 4: miss count.
- `life` input 2: remaining lives.
- `send_bluetooth` output 1: UART TX line to the Bluetooth module; idle high.
- `busy` output 1: high while a frame is on the line.

## Operation
- Line format is 8N1, LSB first: 1 start bit (0), 8 data bits, 1 stop bit (1). There is no gap between bytes.
- Each frame is 4 bytes:
  - B0 = 8'hA5 (header).
  - B1 = {score, miss}.
  - B2 = {state, life, 3'b000}.
  - B3 = B0 ^ B1 ^ B2 (checksum).
- A 13-bit status word is formed as {state, score, miss, life}. `last_sent` holds the word of the most recent frame and resets to 13'h1FFF. State code 3'b111 is unused, so the first frame after reset is guaranteed.
- Frame FSM states: IDLE, START, DATA, STOP.
  - IDLE: if status ≠ `last_sent`, latch the status into `snap` and into `last_sent`, set byte index = 0, go to START. Otherwise stay in IDLE.
  - START: drive 0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: drive `byte[bit]` for DIV cycles per bit. After bit 7, go to STOP.
  - STOP: drive 1 for DIV cycles. If byte index < 3, increment it and go to START. Otherwise go to IDLE.
- All frame bytes come from `snap`. Input changes during a frame are ignored for that frame.
- After a frame, IDLE re-compares immediately. If the inputs changed mid-frame, the next frame starts on the first IDLE cycle.
- Intermediate values that revert before the frame ends are never sent; only the final value is compared.
- No input handshake: the inputs are level status nets and are sampled only in IDLE.

## Timing
- Reset values: `send_bluetooth` = 1, `busy` = 0, FSM = IDLE, all counters = 0, `last_sent` = 13'h1FFF.
- Latency: the inputs change before clock edge N and IDLE observes the mismatch at edge N. `send_bluetooth` falls and `busy` rises at edge N; both are registered outputs.
- Bit period is exactly DIV cycles; the divider counts 0..DIV-1.
- A frame lasts 40·DIV cycles. `busy` falls at the same edge where STOP of B3 completes, and IDLE may start a new frame on that same edge.
- Back-to-back frames: the minimum spacing is 0 cycles of idle line.
- Asserting reset mid-frame aborts immediately: the line goes high and the partial frame is not resumed. After release, the first frame is resent because `last_sent` is reset.

## Structure
- Shared package `bt_pkg`: `BT_HDR = 8'hA5`, frame length `BT_FRAME_BYTES = 4`, and the game state encodings (000 reset, 001 menu, 010 play, 100 done, 101/110 end screens). The receiver uses the same encodings.
- One sub-module, `uart_tx_byte`: a DIV-parameterized byte serializer with `start`/`data[7:0]`/`ready`.
- The top-level FSM sequences bytes, builds the frame, and handles change detection.

## Test plan
Benches use CLK_FREQ=16, BAUD=1, so DIV=16.
- Reset release with state=001, score=0, miss=0, life=3 -> frame starts on the first clock: bytes A5, 00, 38, 9D; `busy` is high for exactly 640 cycles.
- Idle with unchanged inputs for 2000 cycles -> `send_bluetooth` stays 1 and `busy` stays 0.
- Set score=5, miss=2 (state=010, life=3) -> one frame: A5, 52, 58, AF. Bit-sample the line at mid-bit and check the start and stop bits.
- Change miss 2→3→4 during a frame -> the current frame is unchanged. Exactly one follow-up frame starts with 0 idle cycles and carries miss=4; no frame carries miss=3.
- Assert `rst` at cycle 200 of a frame -> the line goes to 1 in the same cycle. After release, a full frame with the current status is sent.
- Checksum property over random status sequences -> the XOR of all 4 bytes of every captured frame is 0, and every frame's B0 is A5.

Source files
------------

// File: rtl/bt_pkg.sv
// Shared Bluetooth link definitions: frame header/length, game state codes
// (common with the receiver), the packed status word and a frame byte builder.
package bt_pkg;

    localparam logic [7:0] BT_HDR         = 8'hA5;
    localparam int         BT_FRAME_BYTES = 4;

    typedef enum logic [2:0] {
        GS_RESET = 3'b000,
        GS_MENU  = 3'b001,
        GS_PLAY  = 3'b010,
        GS_DONE  = 3'b100,
        GS_END_A = 3'b101,
        GS_END_B = 3'b110
    } game_state_e;

    // Byte serializer states.
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    // 13-bit status word {state, score, miss, life}.
    typedef struct packed {
        logic [2:0] state;
        logic [3:0] score;
        logic [3:0] miss;
        logic [1:0] life;
    } bt_status_t;

    // Byte idx of the frame for status s: header, {score,miss},
    // {state,life,000}, then the XOR checksum of the first three.
    function automatic logic [7:0] bt_frame_byte(input bt_status_t s, input logic [1:0] idx);
        logic [7:0] b1;
        logic [7:0] b2;
        b1 = {s.score, s.miss};
        b2 = {s.state, s.life, 3'b000};
        case (idx)
            2'd0:    bt_frame_byte = BT_HDR;
            2'd1:    bt_frame_byte = b1;
            2'd2:    bt_frame_byte = b2;
            default: bt_frame_byte = BT_HDR ^ b1 ^ b2;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first, DIV clocks per bit.
//   clk, rst   : clock, async active-low reset
//   start/data : load a byte; honoured only while ready is high
//   ready      : idle, or on the last cycle of the stop bit, so the next
//                byte follows the stop bit with no idle gap
//   tx         : registered line output, idle high
module uart_tx_byte
    import bt_pkg::*;
#(
    parameter int DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    tx_state_e       state_q, state_d;
    logic [CW-1:0]   div_q, div_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      sh_q, sh_d;
    logic            tx_q, tx_d;
    logic            div_last;

    assign div_last = (div_q == CW'(DIV - 1));
    assign ready    = (state_q == TX_IDLE) || ((state_q == TX_STOP) && div_last);
    assign tx       = tx_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= TX_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
        end
    end

    // tx_d is the value of the bit period that begins at the next edge,
    // so the line changes exactly on bit boundaries.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        case (state_q)
            TX_IDLE: begin
                if (start) begin
                    state_d = TX_START;
                    div_d   = '0;
                    sh_d    = data;
                    tx_d    = 1'b0;
                end
            end
            TX_START: begin
                if (div_last) begin
                    state_d = TX_DATA;
                    div_d   = '0;
                    bit_d   = '0;
                    tx_d    = sh_q[0];
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (div_last) begin
                    div_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        sh_d  = {1'b0, sh_q[7:1]};
                        tx_d  = sh_q[1];
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (div_last) begin
                    div_d = '0;
                    if (start) begin
                        state_d = TX_START;
                        sh_d    = data;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

endmodule

// File: rtl/bt_status_tx.sv
// Bluetooth status transmitter: whenever {state,score,miss,life} differs from
// the last frame sent, emits a 4-byte UART frame (A5, {score,miss},
// {state,life,000}, XOR checksum) built from a snapshot of the status.
//   clk, rst               : clock, async active-low reset
//   state/score/miss/life  : level game status, sampled only between frames
//   send_bluetooth         : UART TX line (8N1, idle high), registered
//   busy                   : high while a frame is on the line, registered
module bt_status_tx
    import bt_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] state,
    input  logic [3:0] score,
    input  logic [3:0] miss,
    input  logic [1:0] life,
    output logic       send_bluetooth,
    output logic       busy
);

    // Truncating division; must come out at least 2.
    localparam int DIV = CLK_FREQ / BAUD;

    bt_status_t status;
    bt_status_t last_sent_q, last_sent_d;
    bt_status_t snap_q, snap_d;
    logic [1:0] idx_q, idx_d;
    logic       busy_q, busy_d;
    logic       tx_start, tx_ready;
    logic [7:0] tx_data;
    logic       frame_done;

    assign status = '{state: state, score: score, miss: miss, life: life};

    uart_tx_byte #(.DIV(DIV)) u_tx (
        .clk   (clk),
        .rst   (rst),
        .start (tx_start),
        .data  (tx_data),
        .ready (tx_ready),
        .tx    (send_bluetooth)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_sent_q <= '1;  // state 111 is never used, so the first frame always goes out
            snap_q      <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            last_sent_q <= last_sent_d;
            snap_q      <= snap_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
        end
    end

    // The last byte's stop bit completing counts as idle, so a pending
    // change starts the next frame on that same edge (no idle line).
    assign frame_done = busy_q && tx_ready && (idx_q == 2'(BT_FRAME_BYTES - 1));

    always_comb begin
        last_sent_d = last_sent_q;
        snap_d      = snap_q;
        idx_d       = idx_q;
        busy_d      = busy_q;
        tx_start    = 1'b0;
        tx_data     = BT_HDR;
        if (busy_q && tx_ready) begin
            if (frame_done) begin
                busy_d = 1'b0;
            end else begin
                tx_start = 1'b1;
                idx_d    = idx_q + 2'd1;
                tx_data  = bt_frame_byte(snap_q, idx_q + 2'd1);
            end
        end
        if ((!busy_q || frame_done) && (status != last_sent_q)) begin
            tx_start    = 1'b1;
            tx_data     = BT_HDR;
            snap_d      = status;
            last_sent_d = status;
            idx_d       = '0;
            busy_d      = 1'b1;
        end
    end

    assign busy = busy_q;

endmodule
